// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants for the machine-mode CSR/trap controller: CSR addresses,
// funct3 codes, request kinds, mcause values and FSM state encodings.
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MEPC_ADDR  = 12'h341;
  localparam logic [11:0] CSR_MTVEC_ADDR = 12'h305;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    KIND_CSR    = 2'd0,
    KIND_ECALL  = 2'd1,
    KIND_EBREAK = 2'd2,
    KIND_MRET   = 2'd3
  } req_kind_e;

  localparam logic [31:0] MCAUSE_ILLEGAL_INSTR = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT    = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_M       = 32'd11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_TRAP  = 3'd3,
    ST_RET   = 3'd4
  } state_e;

  // funct3 values 000 and 100 are not CSR ops and raise an illegal-instruction trap
  function automatic logic is_illegal_funct3(input logic [2:0] funct3);
    return funct3[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_rmw_alu.sv
// Read-modify-write datapath for CSR instructions: computes the new CSR value
// and whether the instruction is allowed to write the CSR at all.
module csr_rmw_alu
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      zimm,
  input  logic            rs1_is_x0,
  output logic [XLEN-1:0] new_val,
  output logic            we
);

  logic [XLEN-1:0] operand;
  logic            src_is_zero;

  // Set/clear with a zero source must leave the CSR untouched (no side effects)
  always_comb begin
    operand     = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_val;
    src_is_zero = funct3[2] ? (zimm == 5'd0) : rs1_is_x0;
    new_val     = old_val;
    we          = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: begin
        new_val = operand;
        we      = 1'b1;
      end
      F3_CSRRS, F3_CSRRSI: begin
        new_val = old_val | operand;
        we      = ~src_is_zero;
      end
      F3_CSRRC, F3_CSRRCI: begin
        new_val = old_val & ~operand;
        we      = ~src_is_zero;
      end
      default: begin
        new_val = old_val;
        we      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Control side of the machine-mode CSR file: sequences CSR read-modify-write
// ops and issues trap entry / MRET redirects through mtvec and mepc.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_zimm,
  input  logic            req_rs1_is_x0,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rd_val,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [11:0]     csr_r_addr,
  input  logic [XLEN-1:0] csr_r_val,
  output logic [11:0]     csr_w_addr,
  output logic [XLEN-1:0] csr_w_val,
  output logic            w_enable,
  output logic            exception_asserted,
  output logic [XLEN-1:0] exception_mepc,
  output logic [XLEN-1:0] exception_mcause,
  input  logic [XLEN-1:0] mtvec
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     csr_q, csr_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d;
  logic [4:0]      zimm_q, zimm_d;
  logic            rs1_is_x0_q, rs1_is_x0_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] old_q, old_d;

  logic [XLEN-1:0] alu_new_val;
  logic            alu_we;

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .funct3    (funct3_q),
    .old_val   (old_q),
    .rs1_val   (rs1_val_q),
    .zimm      (zimm_q),
    .rs1_is_x0 (rs1_is_x0_q),
    .new_val   (alu_new_val),
    .we        (alu_we)
  );

  always_comb begin
    state_d            = state_q;
    funct3_d           = funct3_q;
    csr_d              = csr_q;
    rs1_val_d          = rs1_val_q;
    zimm_d             = zimm_q;
    rs1_is_x0_d        = rs1_is_x0_q;
    pc_d               = pc_q;
    cause_d            = cause_q;
    old_d              = old_q;
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_rd_val        = '0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    csr_r_addr         = '0;
    csr_w_addr         = '0;
    csr_w_val          = '0;
    w_enable           = 1'b0;
    exception_asserted = 1'b0;
    exception_mepc     = '0;
    exception_mcause   = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d    = req_funct3;
          csr_d       = req_csr;
          rs1_val_d   = req_rs1_val;
          zimm_d      = req_zimm;
          rs1_is_x0_d = req_rs1_is_x0;
          pc_d        = req_pc;
          case (req_kind_e'(req_kind))
            KIND_CSR: begin
              if (is_illegal_funct3(req_funct3)) begin
                cause_d = MCAUSE_ILLEGAL_INSTR;
                state_d = ST_TRAP;
              end else begin
                state_d = ST_READ;
              end
            end
            KIND_ECALL: begin
              cause_d = MCAUSE_ECALL_M;
              state_d = ST_TRAP;
            end
            KIND_EBREAK: begin
              cause_d = MCAUSE_BREAKPOINT;
              state_d = ST_TRAP;
            end
            default: state_d = ST_RET;
          endcase
        end
      end
      ST_READ: begin
        csr_r_addr = csr_q;
        old_d      = csr_r_val;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        w_enable    = alu_we;
        csr_w_addr  = csr_q;
        csr_w_val   = alu_new_val;
        resp_valid  = 1'b1;
        resp_rd_val = old_q;
        state_d     = ST_IDLE;
      end
      ST_TRAP: begin
        exception_asserted = 1'b1;
        exception_mepc     = pc_q;
        exception_mcause   = cause_q;
        redirect_valid     = 1'b1;
        redirect_pc        = mtvec & ALIGN_MASK;
        state_d            = ST_IDLE;
      end
      ST_RET: begin
        csr_r_addr     = CSR_MEPC_ADDR;
        redirect_valid = 1'b1;
        redirect_pc    = csr_r_val & ALIGN_MASK;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset silences every output in the same cycle so no write or trap leaks out
    if (reset) begin
      state_d            = ST_IDLE;
      req_ready          = 1'b0;
      resp_valid         = 1'b0;
      resp_rd_val        = '0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      csr_r_addr         = '0;
      csr_w_addr         = '0;
      csr_w_val          = '0;
      w_enable           = 1'b0;
      exception_asserted = 1'b0;
      exception_mepc     = '0;
      exception_mcause   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      csr_q       <= '0;
      rs1_val_q   <= '0;
      zimm_q      <= '0;
      rs1_is_x0_q <= 1'b0;
      pc_q        <= '0;
      cause_q     <= '0;
      old_q       <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      csr_q       <= csr_d;
      rs1_val_q   <= rs1_val_d;
      zimm_q      <= zimm_d;
      rs1_is_x0_q <= rs1_is_x0_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      old_q       <= old_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: directed requests push hand-computed
// responses; a negedge monitor pops and compares whenever the DUT responds.
module tb_csr_trap_ctrl;

  typedef struct {
    bit          is_redir;
    int          due_cycle;
    logic [31:0] rd;
    bit          wen;
    logic [11:0] waddr;
    logic [31:0] wval;
    bit          exc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] rpc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_zimm;
  logic        req_rs1_is_x0;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rd_val;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_r_addr;
  logic [31:0] csr_r_val;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_val;
  logic        w_enable;
  logic        exception_asserted;
  logic [31:0] exception_mepc;
  logic [31:0] exception_mcause;
  logic [31:0] mtvec;

  logic [31:0] csr_mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_val;

  exp_t exp_q[$];
  int   cycle_cnt;
  int   n_checks;
  int   n_pass;
  int   probe_id;
  int   probe_kind;
  bit   probe_ready;

  csr_trap_ctrl #(.XLEN(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_kind           (req_kind),
    .req_funct3         (req_funct3),
    .req_csr            (req_csr),
    .req_rs1_val        (req_rs1_val),
    .req_zimm           (req_zimm),
    .req_rs1_is_x0      (req_rs1_is_x0),
    .req_pc             (req_pc),
    .resp_valid         (resp_valid),
    .resp_rd_val        (resp_rd_val),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .csr_r_addr         (csr_r_addr),
    .csr_r_val          (csr_r_val),
    .csr_w_addr         (csr_w_addr),
    .csr_w_val          (csr_w_val),
    .w_enable           (w_enable),
    .exception_asserted (exception_asserted),
    .exception_mepc     (exception_mepc),
    .exception_mcause   (exception_mcause),
    .mtvec              (mtvec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Behavioural CSR file: combinational read, write commits at the clock edge
  assign csr_r_val = csr_mem[csr_r_addr];
  always @(posedge clock) begin
    if (pre_en) csr_mem[pre_addr] <= pre_val;
    else if (w_enable) csr_mem[csr_w_addr] <= csr_w_val;
  end

  task automatic preload(input logic [11:0] addr, input logic [31:0] val);
    @(negedge clock);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_val  = val;
    @(negedge clock);
    pre_en   = 1'b0;
  endtask

  task automatic probe(input int kind, input bit ready_want);
    probe_kind  = kind;
    probe_ready = ready_want;
    probe_id    = probe_id + 1;
  endtask

  function automatic exp_t mkResp(input logic [31:0] rd, input bit wen,
                                  input logic [11:0] waddr, input logic [31:0] wval);
    exp_t e;
    e = '{default: '0};
    e.is_redir = 1'b0;
    e.rd = rd;
    e.wen = wen;
    e.waddr = waddr;
    e.wval = wval;
    return e;
  endfunction

  function automatic exp_t mkRedir(input logic [31:0] rpc, input bit exc,
                                   input logic [31:0] mepc, input logic [31:0] mcause);
    exp_t e;
    e = '{default: '0};
    e.is_redir = 1'b1;
    e.rpc = rpc;
    e.exc = exc;
    e.mepc = mepc;
    e.mcause = mcause;
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3,
                               input logic [11:0] csr, input logic [31:0] rs1,
                               input logic [4:0] zimm, input bit x0,
                               input logic [31:0] pc, input bit do_push, input exp_t e);
    exp_t ex;
    int   waited;
    ex = e;
    req_kind      = kind;
    req_funct3    = f3;
    req_csr       = csr;
    req_rs1_val   = rs1;
    req_zimm      = zimm;
    req_rs1_is_x0 = x0;
    req_pc        = pc;
    req_valid     = 1'b1;
    waited        = 0;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      waited++;
      if (waited > 50) begin
        $display("[TB] FAIL handshake_timeout actual=req_ready low required=accept within 50 cycles");
        $fatal(1, "[TB] handshake timeout");
      end
    end
    if (do_push) begin
      ex.due_cycle = cycle_cnt + (ex.is_redir ? 1 : 2);
      exp_q.push_back(ex);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] want);
    n_checks++;
    if (actual === want) n_pass++;
    else $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, want);
  endtask

  // Monitor: pops the scoreboard whenever a response or redirect appears
  initial begin
    exp_t        e;
    logic [31:0] zero_vec;
    int          probe_seen;
    n_checks   = 0;
    n_pass     = 0;
    probe_seen = 0;
    forever begin
      @(negedge clock);
      if (probe_id != probe_seen) begin
        probe_seen = probe_id;
        if (probe_kind == 3) begin
          checkOutput("queue_empty", exp_q.size(), 32'd0);
        end else begin
          checkOutput("req_ready", {31'b0, req_ready}, {31'b0, probe_ready});
          if (probe_kind == 2) begin
            zero_vec = {28'b0, resp_valid, redirect_valid, w_enable, exception_asserted}
                     | resp_rd_val | redirect_pc | csr_w_val | exception_mepc
                     | exception_mcause | {20'b0, csr_r_addr} | {20'b0, csr_w_addr};
            checkOutput("reset_outputs_or", zero_vec, 32'd0);
          end
        end
      end
      if (w_enable && !resp_valid)
        checkOutput("stray_w_enable", {31'b0, w_enable}, 32'd0);
      if (exception_asserted && !redirect_valid)
        checkOutput("stray_exception", {31'b0, exception_asserted}, 32'd0);
      if (resp_valid || redirect_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", {30'b0, resp_valid, redirect_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("latency_cycle", cycle_cnt, e.due_cycle);
          checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, !e.is_redir});
          checkOutput("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.is_redir});
          checkOutput("w_enable", {31'b0, w_enable}, {31'b0, e.wen});
          checkOutput("exception_asserted", {31'b0, exception_asserted}, {31'b0, e.exc});
          if (!e.is_redir) begin
            checkOutput("resp_rd_val", resp_rd_val, e.rd);
            if (e.wen) begin
              checkOutput("csr_w_addr", {20'b0, csr_w_addr}, {20'b0, e.waddr});
              checkOutput("csr_w_val", csr_w_val, e.wval);
            end
          end else begin
            checkOutput("redirect_pc", redirect_pc, e.rpc);
            if (e.exc) begin
              checkOutput("exception_mepc", exception_mepc, e.mepc);
              checkOutput("exception_mcause", exception_mcause, e.mcause);
            end
          end
        end
      end
    end
  end

  initial begin
    exp_t none;
    none          = '{default: '0};
    probe_id      = 0;
    probe_kind    = 0;
    probe_ready   = 1'b0;
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_kind      = 2'd0;
    req_funct3    = 3'd0;
    req_csr       = 12'h0;
    req_rs1_val   = 32'h0;
    req_zimm      = 5'd0;
    req_rs1_is_x0 = 1'b0;
    req_pc        = 32'h0;
    mtvec         = 32'h0000_0203;
    pre_en        = 1'b0;
    pre_addr      = 12'h0;
    pre_val       = 32'h0;

    preload(12'h340, 32'h0000_0000);
    preload(12'h300, 32'hDEAD_BEEF);
    preload(12'h304, 32'h0000_00FF);
    preload(12'h341, 32'h0000_0104);
    preload(12'h305, 32'hAAAA_5555);

    @(posedge clock);
    #1 probe(2, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    probe(1, 1'b1);

    applyStimulus(2'd0, 3'b001, 12'h340, 32'h1234_5678, 5'd0, 1'b0, 32'h0, 1'b1,
                  mkResp(32'h0, 1'b1, 12'h340, 32'h1234_5678));
    applyStimulus(2'd0, 3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0, 1'b1,
                  mkResp(32'h1234_5678, 1'b0, 12'h0, 32'h0));
    applyStimulus(2'd0, 3'b010, 12'h300, 32'h0000_0000, 5'd0, 1'b1, 32'h0, 1'b1,
                  mkResp(32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0));
    applyStimulus(2'd0, 3'b111, 12'h304, 32'h0, 5'h0F, 1'b0, 32'h0, 1'b1,
                  mkResp(32'h0000_00FF, 1'b1, 12'h304, 32'h0000_00F0));
    applyStimulus(2'd0, 3'b110, 12'h304, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0, 1'b1,
                  mkResp(32'h0000_00F0, 1'b0, 12'h0, 32'h0));
    applyStimulus(2'd0, 3'b011, 12'h340, 32'h0000_0078, 5'd0, 1'b0, 32'h0, 1'b1,
                  mkResp(32'h1234_5678, 1'b1, 12'h340, 32'h1234_5600));
    applyStimulus(2'd0, 3'b101, 12'h304, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0, 1'b1,
                  mkResp(32'h0000_00F0, 1'b1, 12'h304, 32'h0000_0000));
    applyStimulus(2'd0, 3'b010, 12'h300, 32'h0000_0011, 5'd0, 1'b0, 32'h0, 1'b1,
                  mkResp(32'hDEAD_BEEF, 1'b1, 12'h300, 32'hDEAD_BEFF));

    applyStimulus(2'd1, 3'b000, 12'h0, 32'h0, 5'd0, 1'b0, 32'h0000_0100, 1'b1,
                  mkRedir(32'h0000_0200, 1'b1, 32'h0000_0100, 32'd11));
    applyStimulus(2'd2, 3'b001, 12'h0, 32'h0, 5'd0, 1'b0, 32'h0000_2004, 1'b1,
                  mkRedir(32'h0000_0200, 1'b1, 32'h0000_2004, 32'd3));
    applyStimulus(2'd3, 3'b000, 12'h0, 32'h0, 5'd0, 1'b0, 32'h0000_0500, 1'b1,
                  mkRedir(32'h0000_0104, 1'b0, 32'h0, 32'h0));
    applyStimulus(2'd0, 3'b100, 12'h300, 32'h0, 5'd0, 1'b0, 32'h0000_0300, 1'b1,
                  mkRedir(32'h0000_0200, 1'b1, 32'h0000_0300, 32'd2));
    applyStimulus(2'd0, 3'b000, 12'h340, 32'h0, 5'd0, 1'b0, 32'h0000_0304, 1'b1,
                  mkRedir(32'h0000_0200, 1'b1, 32'h0000_0304, 32'd2));

    // Reset lands while a CSRRW sits in READ; its write must never appear
    applyStimulus(2'd0, 3'b001, 12'h305, 32'h0000_0001, 5'd0, 1'b0, 32'h0, 1'b0, none);
    reset = 1'b1;
    @(posedge clock);
    #1 probe(2, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    probe(1, 1'b1);
    applyStimulus(2'd0, 3'b010, 12'h305, 32'h0, 5'd0, 1'b1, 32'h0, 1'b1,
                  mkResp(32'hAAAA_5555, 1'b0, 12'h0, 32'h0));

    repeat (6) @(posedge clock);
    #1 probe(3, 1'b0);
    repeat (2) @(posedge clock);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=still running required=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
